// File: rtl/brdg_axi_slave_cmd_arb_fifo.sv
// Multi-channel AXI command merger: one FWFT FIFO per input channel, drained by a
// round-robin arbiter that locks onto the presented command until it is accepted.
module brdg_axi_slave_cmd_arb_fifo #(
    parameter int IDW        = 5,
    parameter int CTXW       = 9,
    parameter int N_CH       = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_MARGIN  = 2,
    localparam int W         = IDW + 64 + 8 + 3 + 2 + CTXW,
    localparam int CHW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_CH-1:0]                s_valid,
    output logic [N_CH-1:0]                s_ready,
    input  logic [N_CH*IDW-1:0]            s_id,
    input  logic [N_CH*64-1:0]             s_addr,
    input  logic [N_CH*8-1:0]              s_len,
    input  logic [N_CH*3-1:0]              s_size,
    input  logic [N_CH*2-1:0]              s_burst,
    input  logic [N_CH*CTXW-1:0]           s_user,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [CHW-1:0]                 m_ch,
    output logic [IDW-1:0]                 m_id,
    output logic [63:0]                    m_addr,
    output logic [7:0]                     m_len,
    output logic [2:0]                     m_size,
    output logic [1:0]                     m_burst,
    output logic [CTXW-1:0]                m_user,
    output logic [N_CH*(ADDR_WIDTH+1)-1:0] ch_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] THRESH = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [W-1:0]          mem    [N_CH][DEPTH];
    logic [W-1:0]          in_word[N_CH];
    logic [ADDR_WIDTH-1:0] wr_ptr [N_CH];
    logic [ADDR_WIDTH-1:0] rd_ptr [N_CH];
    logic [ADDR_WIDTH:0]   count  [N_CH];
    logic [N_CH-1:0]       nonempty;
    logic [N_CH-1:0]       push;
    logic [N_CH-1:0]       pop_ch;
    logic [CHW-1:0]        rr_ptr;
    logic [CHW-1:0]        sel;
    logic [CHW-1:0]        lock_ch;
    logic [CHW-1:0]        cur_ch;
    logic [W-1:0]          head;
    logic                  found;
    logic                  pop;

    // Ready is derived only from registered occupancy, never from s_valid.
    always_comb begin
        s_ready  = '0;
        nonempty = '0;
        push     = '0;
        pop_ch   = '0;
        ch_count = '0;
        for (int c = 0; c < N_CH; c++) begin
            in_word[c]  = {s_id[c*IDW +: IDW], s_addr[c*64 +: 64], s_len[c*8 +: 8],
                           s_size[c*3 +: 3], s_burst[c*2 +: 2], s_user[c*CTXW +: CTXW]};
            nonempty[c] = (count[c] != '0);
            s_ready[c]  = (count[c] < THRESH);
            push[c]     = s_valid[c] & s_ready[c];
            pop_ch[c]   = pop && (cur_ch == CHW'(c));
            ch_count[c*(ADDR_WIDTH+1) +: (ADDR_WIDTH+1)] = count[c];
        end
    end

    // First nonempty channel at or after rr_ptr, wrapping modulo N_CH.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && nonempty[(int'(rr_ptr) + i) % N_CH]) begin
                sel   = CHW'((int'(rr_ptr) + i) % N_CH);
                found = 1'b1;
            end
        end
    end

    assign cur_ch  = (state == LOCKED) ? lock_ch : sel;
    assign m_ch    = cur_ch;
    assign m_valid = |nonempty;
    assign pop     = m_valid & m_ready;
    assign head    = mem[cur_ch][rd_ptr[cur_ch]];
    assign {m_id, m_addr, m_len, m_size, m_burst, m_user} = head;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (m_valid && !m_ready) state_nxt = LOCKED;
            LOCKED:  if (pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // lock_ch tracks sel while idle so it holds the presented channel once locked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            lock_ch <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) lock_ch <= sel;
            if (pop) rr_ptr <= CHW'((int'(cur_ch) + 1) % N_CH);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (push[c])   wr_ptr[c] <= wr_ptr[c] + ADDR_WIDTH'(1);
                if (pop_ch[c]) rd_ptr[c] <= rd_ptr[c] + ADDR_WIDTH'(1);
                if (push[c] && !pop_ch[c])      count[c] <= count[c] + (ADDR_WIDTH+1)'(1);
                else if (!push[c] && pop_ch[c]) count[c] <= count[c] - (ADDR_WIDTH+1)'(1);
            end
        end
    end

    // Storage is intentionally not reset; only pointers and counts define validity.
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (push[c]) mem[c][wr_ptr[c]] <= in_word[c];
        end
    end

endmodule

// File: tb/tb_brdg_axi_slave_cmd_arb_fifo.sv
// Bench for brdg_axi_slave_cmd_arb_fifo: a per-channel queue model tracks every
// accepted command and checks each merged pop, plus directed arbitration/lock/full cases.
module tb_brdg_axi_slave_cmd_arb_fifo;

    localparam int IDW  = 5;
    localparam int CTXW = 9;
    localparam int N    = 2;
    localparam int W    = IDW + 64 + 8 + 3 + 2 + CTXW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    s_valid, sv_b;
    logic [N*IDW-1:0]  s_id;
    logic [N*64-1:0]   s_addr;
    logic [N*8-1:0]    s_len;
    logic [N*3-1:0]    s_size;
    logic [N*2-1:0]    s_burst;
    logic [N*CTXW-1:0] s_user;
    logic            m_ready, mr_b;

    logic [N-1:0]    s_ready, sr_b;
    logic            m_valid, mv_b;
    logic            m_ch, mch_b;
    logic [IDW-1:0]  m_id, mid_b;
    logic [63:0]     m_addr, maddr_b;
    logic [7:0]      m_len, mlen_b;
    logic [2:0]      m_size, msize_b;
    logic [1:0]      m_burst, mburst_b;
    logic [CTXW-1:0] m_user, muser_b;
    logic [9:0]      ch_count, cc_b;

    int n_checks = 0;
    int n_fail   = 0;

    brdg_axi_slave_cmd_arb_fifo u_dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_id(s_id), .s_addr(s_addr), .s_len(s_len), .s_size(s_size),
        .s_burst(s_burst), .s_user(s_user), .m_valid(m_valid), .m_ready(m_ready),
        .m_ch(m_ch), .m_id(m_id), .m_addr(m_addr), .m_len(m_len), .m_size(m_size),
        .m_burst(m_burst), .m_user(m_user), .ch_count(ch_count)
    );

    // Second instance with no almost-full margin, for full-channel behaviour.
    brdg_axi_slave_cmd_arb_fifo #(.AF_MARGIN(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(sv_b), .s_ready(sr_b),
        .s_id(s_id), .s_addr(s_addr), .s_len(s_len), .s_size(s_size),
        .s_burst(s_burst), .s_user(s_user), .m_valid(mv_b), .m_ready(mr_b),
        .m_ch(mch_b), .m_id(mid_b), .m_addr(maddr_b), .m_len(mlen_b), .m_size(msize_b),
        .m_burst(mburst_b), .m_user(muser_b), .ch_count(cc_b)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int c, input logic [63:0] addr);
        s_id[c*IDW +: IDW]     = IDW'($urandom_range(0, 31));
        s_addr[c*64 +: 64]     = addr;
        s_len[c*8 +: 8]        = 8'($urandom_range(0, 255));
        s_size[c*3 +: 3]       = 3'($urandom_range(0, 7));
        s_burst[c*2 +: 2]      = 2'($urandom_range(0, 3));
        s_user[c*CTXW +: CTXW] = CTXW'($urandom_range(0, 511));
    endtask

    function automatic logic [W-1:0] in_word(input int c);
        return {s_id[c*IDW +: IDW], s_addr[c*64 +: 64], s_len[c*8 +: 8],
                s_size[c*3 +: 3], s_burst[c*2 +: 2], s_user[c*CTXW +: CTXW]};
    endfunction

    // Scoreboard: expected entries per channel plus an optional expected pop order.
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int           exp_ch_q[$];
    logic [N-1:0] mon_rdy;
    logic [W-1:0] mon_word;
    logic [W-1:0] hold_word;
    logic         hold = 1'b0;
    logic         hold_ch;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
            exp_ch_q.delete();
            hold = 1'b0;
        end else begin
            mon_rdy[0] = exp_q0.size() < 14;
            mon_rdy[1] = exp_q1.size() < 14;
            mon_word   = {m_id, m_addr, m_len, m_size, m_burst, m_user};
            check("s_ready", s_ready, mon_rdy);
            check("m_valid", m_valid, (exp_q0.size() != 0) || (exp_q1.size() != 0));
            check("ch_count0", ch_count[4:0], exp_q0.size());
            check("ch_count1", ch_count[9:5], exp_q1.size());
            if (hold) begin
                check("hold_ch", m_ch, hold_ch);
                check("hold_data", mon_word, hold_word);
            end
            if (m_valid && m_ready) begin
                if (exp_ch_q.size() != 0) check("pop_order", m_ch, exp_ch_q.pop_front());
                if (m_ch == 1'b0 && exp_q0.size() != 0) check("pop_data0", mon_word, exp_q0.pop_front());
                else if (m_ch == 1'b1 && exp_q1.size() != 0) check("pop_data1", mon_word, exp_q1.pop_front());
                else check("pop_from_empty", 1, 0);
            end
            if (s_valid[0] && mon_rdy[0]) exp_q0.push_back(in_word(0));
            if (s_valid[1] && mon_rdy[1]) exp_q1.push_back(in_word(1));
            hold      = m_valid && !m_ready;
            hold_ch   = m_ch;
            hold_word = mon_word;
        end
    end

    task automatic drain();
        int n;
        n = 0;
        s_valid = '0;
        m_ready = 1'b1;
        while (m_valid && n < 100) begin
            tick();
            n++;
        end
        check("drain_done", m_valid, 0);
        m_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; s_valid = '0; sv_b = '0; m_ready = 1'b0; mr_b = 1'b0;
        set_fields(0, 64'h0);
        set_fields(1, 64'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_m_ch", m_ch, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_s_ready", s_ready, 2'b11);
        check("rst_ch_count", ch_count, 0);
        check("rst_b_s_ready", sr_b, 2'b11);

        // Single push, popped the cycle it appears
        tick();
        set_fields(0, 64'h1000);
        s_len[7:0] = 8'd3;
        s_valid = 2'b01; m_ready = 1'b1;
        exp_ch_q.push_back(0);
        tick();
        s_valid = '0;
        @(negedge clk);
        check("single_valid", m_valid, 1);
        check("single_ch", m_ch, 0);
        check("single_addr", m_addr, 64'h1000);
        check("single_len", m_len, 3);
        tick();
        @(negedge clk);
        check("single_after_valid", m_valid, 0);
        check("single_after_count", ch_count, 0);

        // Fill ch1 to the almost-full threshold with s_valid held high
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_fields(1, 64'h2000 + i);
            s_valid = 2'b10;
            tick();
        end
        @(negedge clk);
        check("fill_count", ch_count[9:5], 14);
        check("fill_ready", s_ready[1], 0);
        tick();
        @(negedge clk);
        check("fill_count_held", ch_count[9:5], 14);
        repeat (14) exp_ch_q.push_back(1);
        drain();

        // Round robin with both channels loaded
        for (int i = 0; i < 3; i++) begin
            set_fields(0, 64'h3000 + i);
            set_fields(1, 64'h3100 + i);
            s_valid = 2'b11;
            tick();
        end
        s_valid = '0;
        for (int i = 0; i < 3; i++) begin
            exp_ch_q.push_back(0);
            exp_ch_q.push_back(1);
        end
        drain();

        // Lock on ch1 while ch0 receives pushes
        set_fields(1, 64'h4000);
        s_valid = 2'b10;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                set_fields(0, 64'h4100 + i);
                s_valid = 2'b01;
            end else begin
                s_valid = '0;
            end
            @(negedge clk);
            check("lock_ch", m_ch, 1);
            check("lock_addr", m_addr, 64'h4000);
            tick();
        end
        s_valid = '0;
        exp_ch_q.push_back(1);
        repeat (3) exp_ch_q.push_back(0);
        drain();

        // Reset with 7 commands queued
        for (int i = 0; i < 4; i++) begin
            set_fields(0, 64'h5000 + i);
            if (i < 3) set_fields(1, 64'h5100 + i);
            s_valid = (i < 3) ? 2'b11 : 2'b01;
            tick();
        end
        s_valid = '0;
        @(negedge clk);
        check("pre_rst_count0", ch_count[4:0], 4);
        check("pre_rst_count1", ch_count[9:5], 3);
        tick();
        rst_n = 1'b0; m_ready = 1'b1;
        tick();
        rst_n = 1'b1; m_ready = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_count", ch_count, 0);
        check("mid_rst_ready", s_ready, 2'b11);
        tick();
        set_fields(1, 64'h6000);
        s_valid = 2'b10;
        exp_ch_q.push_back(1);
        tick();
        s_valid = '0;
        @(negedge clk);
        check("post_rst_ch", m_ch, 1);
        check("post_rst_addr", m_addr, 64'h6000);
        drain();

        // Random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            set_fields(0, {32'($urandom), 32'(i)});
            set_fields(1, {32'($urandom), 32'(i + 1000)});
            s_valid = 2'($urandom_range(0, 3));
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        check("order_queue_empty", exp_ch_q.size(), 0);

        // Full channel with no margin: blocked push, push+pop, pointer wrap
        s_valid = '0;
        mr_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_fields(0, 64'h100 + i);
            sv_b = 2'b01;
            tick();
        end
        @(negedge clk);
        check("b_full_count", cc_b[4:0], 16);
        check("b_full_ready", sr_b[0], 0);
        check("b_full_head", maddr_b, 64'h100);
        tick();
        set_fields(0, 64'h200);
        sv_b = 2'b01; mr_b = 1'b1;
        @(negedge clk);
        check("b_blocked_ready", sr_b[0], 0);
        tick();
        set_fields(0, 64'h110);
        @(negedge clk);
        check("b_after_pop_count", cc_b[4:0], 15);
        check("b_after_pop_ready", sr_b[0], 1);
        check("b_after_pop_head", maddr_b, 64'h101);
        tick();
        sv_b = '0;
        @(negedge clk);
        check("b_pushpop_count", cc_b[4:0], 15);
        for (int i = 0; i < 15; i++) begin
            check("b_wrap_valid", mv_b, 1);
            check("b_wrap_addr", maddr_b, 64'h102 + i);
            tick();
            @(negedge clk);
        end
        check("b_empty_valid", mv_b, 0);
        check("b_empty_count", cc_b, 0);
        mr_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
